cnn_kernel_sched: RTL



---
 rtl/cnn_kernel_sched_pkg.sv | 38 +++
 rtl/cnn_tag_delay.sv | 47 ++++
 rtl/cnn_kernel_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_kernel_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_kernel_sched_pkg
//  Purpose  : Shared CNN core defines for the kernel scheduler: default layer
//             geometry, kernel latency, derived coordinate widths and the
//             scheduler state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cnn_kernel_sched_pkg;

    // Default layer geometry and kernel pipeline depth
    localparam int C_OX    = 4;
    localparam int C_OY    = 4;
    localparam int C_ICH   = 3;
    localparam int C_K_LAT = 2;

    // Counter width for a range of 'value' entries; never narrower than 1 bit
    // so a degenerate dimension of 1 still yields a legal vector.
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

    localparam int C_XW = clog2_min1(C_OX);
    localparam int C_YW = clog2_min1(C_OY);
    localparam int C_CW = clog2_min1(C_ICH);

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/cnn_tag_delay.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_tag_delay
//  Purpose  : Fixed-depth shift line for side-band tags/valids that must stay
//             aligned with a pipelined datapath. Shifts every cycle; a flush
//             zeroes every stage on the next edge.
//  Ports    : clk      - clock, rising edge
//             reset    - asynchronous active-high reset
//             i_flush  - synchronous clear of all stages (wins over shifting)
//             i_data   - tag entering the line this cycle
//             o_data   - tag that entered DEPTH cycles ago
//  Revision : 1.0 - initial release
// ============================================================================
module cnn_tag_delay #(
    parameter int DEPTH = 2,
    parameter int BW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_flush,
    input  logic [BW-1:0] i_data,
    output logic [BW-1:0] o_data
);

    logic [BW-1:0] line_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign o_data = line_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/cnn_kernel_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_kernel_sched
//  Purpose  : Sequencer for one KXxKY MAC kernel stage. Walks every (y, x, ch)
//             of a layer (ch innermost), issues one window-valid per point,
//             tracks returns from the kernel pipeline, tags first/last channel
//             aligned to the kernel output and pulses done once drained.
//  Ports    : clk, reset     - clock / asynchronous active-high reset
//             i_start        - start pulse, honoured only when idle
//             i_abort        - terminate current layer (any busy state)
//             i_stall        - back-pressure, blocks issue while running
//             i_ker_valid    - kernel result valid
//             o_soft_reset   - kernel/accumulator flush pulse
//             o_win_valid    - window issue strobe to the kernel
//             o_x/o_y/o_ch   - window coordinates, valid with o_win_valid
//             o_acc_first    - returning result belongs to channel 0
//             o_acc_last     - returning result belongs to channel ICH-1
//             o_busy         - any non-idle state
//             o_done         - one-cycle completion pulse
//             o_err          - sticky spurious-return flag
//  Revision : 1.0 - initial release
// ============================================================================
module cnn_kernel_sched
    import cnn_kernel_sched_pkg::*;
#(
    parameter int OX    = C_OX,
    parameter int OY    = C_OY,
    parameter int ICH   = C_ICH,
    parameter int K_LAT = C_K_LAT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic                        i_stall,
    input  logic                        i_ker_valid,
    output logic                        o_soft_reset,
    output logic                        o_win_valid,
    output logic [clog2_min1(OX)-1:0]   o_x,
    output logic [clog2_min1(OY)-1:0]   o_y,
    output logic [clog2_min1(ICH)-1:0]  o_ch,
    output logic                        o_acc_first,
    output logic                        o_acc_last,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int XW = clog2_min1(OX);
    localparam int YW = clog2_min1(OY);
    localparam int CW = clog2_min1(ICH);
    localparam int N  = OX * OY * ICH;
    localparam int NW = $clog2(N + 1);

    sched_state_t  state_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] ch_q;
    logic [NW-1:0] iss_q;
    logic [NW-1:0] ret_q;
    logic          err_q;

    logic          w_abort;
    logic          w_issue;
    logic          w_ch_wrap;
    logic          w_x_wrap;
    logic          w_y_last;
    logic          w_last_issue;
    logic          w_ret_window;
    logic          w_spurious;
    logic          w_ret;
    logic          w_drained;
    logic          w_soft_reset;
    logic [1:0]    w_tag_in;
    logic [1:0]    w_tag_out;

    assign w_abort      = i_abort && (state_q != ST_IDLE);
    assign w_issue      = (state_q == ST_RUN) && !i_stall;
    assign w_ch_wrap    = (ch_q == CW'(ICH - 1));
    assign w_x_wrap     = (x_q  == XW'(OX - 1));
    assign w_y_last     = (y_q  == YW'(OY - 1));
    assign w_last_issue = w_issue && w_ch_wrap && w_x_wrap && w_y_last;

    // A return is legitimate only while something is outstanding; anything
    // else (including any return while idle) is flagged and not counted.
    assign w_ret_window = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                          (state_q == ST_DRAIN);
    assign w_spurious   = i_ker_valid && ((state_q == ST_IDLE) || (ret_q == iss_q));
    assign w_ret        = i_ker_valid && w_ret_window && !w_spurious;

    // Drained counts a return arriving in this very cycle.
    assign w_drained    = (ret_q == NW'(N)) || (w_ret && (ret_q == NW'(N - 1)));

    // Flush on entry to CLEAR and on the abort transition cycle.
    assign w_soft_reset = (state_q == ST_CLEAR) || w_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (w_abort) begin
                state_q <= ST_IDLE;
                x_q     <= '0;
                y_q     <= '0;
                ch_q    <= '0;
                iss_q   <= '0;
                ret_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_start) begin
                            state_q <= ST_CLEAR;
                            x_q     <= '0;
                            y_q     <= '0;
                            ch_q    <= '0;
                            iss_q   <= '0;
                            ret_q   <= '0;
                        end
                    end
                    ST_CLEAR: state_q <= ST_RUN;
                    ST_RUN: begin
                        if (w_last_issue) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_drained) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE:  state_q <= ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase

                // Window walk: ch innermost, then x, then y. y wraps after
                // the final issue so the counters rest at zero.
                if (w_issue) begin
                    if (w_ch_wrap) begin
                        ch_q <= '0;
                        if (w_x_wrap) begin
                            x_q <= '0;
                            y_q <= w_y_last ? '0 : y_q + YW'(1);
                        end else begin
                            x_q <= x_q + XW'(1);
                        end
                    end else begin
                        ch_q <= ch_q + CW'(1);
                    end
                    iss_q <= iss_q + NW'(1);
                end

                if (w_ret) begin
                    ret_q <= ret_q + NW'(1);
                end
            end

            // A new layer clears the sticky error; otherwise it only sets.
            if ((state_q == ST_IDLE) && i_start) begin
                err_q <= 1'b0;
            end else if (w_spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag {first, last} rides alongside the kernel pipeline.
    assign w_tag_in = w_issue ? {(ch_q == '0), w_ch_wrap} : 2'b00;

    cnn_tag_delay #(
        .DEPTH (K_LAT),
        .BW    (2)
    ) u_tag_delay (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_soft_reset),
        .i_data  (w_tag_in),
        .o_data  (w_tag_out)
    );

    assign o_soft_reset = w_soft_reset;
    assign o_win_valid  = w_issue;
    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_ch         = ch_q;
    assign o_acc_first  = w_tag_out[1] && i_ker_valid;
    assign o_acc_last   = w_tag_out[0] && i_ker_valid;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = (state_q == ST_DONE);
    assign o_err        = err_q;

endmodule
`default_nettype wire
